// File: rtl/freq_display_ctrl.sv
// freq_display_ctrl: accepts one binary count per valid/ready handshake and
// converts it to eight BCD digits with a serial double-dabble engine. It then
// sets the range decimal point and, optionally, blanks leading zeros. All
// digit/dp outputs and the overflow flag update together on the LOAD edge.
// Optional feature: define FREQ_DISP_LZB_EN to enable leading-zero blanking.
module freq_display_ctrl #(
    parameter int unsigned CNT_WIDTH  = 27,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_valid,
    output logic                 cnt_ready,
    input  logic [CNT_WIDTH-1:0] cnt_data,
    input  logic [1:0]           range_sel,
    output logic [3:0]           digit0,
    output logic [3:0]           digit1,
    output logic [3:0]           digit2,
    output logic [3:0]           digit3,
    output logic [3:0]           digit4,
    output logic [3:0]           digit5,
    output logic [3:0]           digit6,
    output logic [3:0]           digit7,
    output logic                 dp0,
    output logic                 dp1,
    output logic                 dp2,
    output logic                 dp3,
    output logic                 dp4,
    output logic                 dp5,
    output logic                 dp6,
    output logic                 dp7,
    output logic                 busy,
    output logic                 ovf
);

    typedef enum logic [1:0] {StIdle, StConv, StBlank, StLoad} state_t;

    localparam logic [31:0] SatMax = 32'd99_999_999;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] bin_q;
    logic [31:0]          bcd_q;
    logic [5:0]           bit_cnt_q;
    logic [1:0]           range_q;
    logic                 ovf_pend_q;
    logic [31:0]          digit_pend_q;
    logic [7:0]           dp_pend_q;
    logic [31:0]          disp_q;
    logic [7:0]           dp_q;
    logic                 ovf_q;

    logic [31:0]          cnt_ext;
    logic                 sat;
    logic [31:0]          bcd_adj;
    logic [2:0]           dp_idx;
    logic                 dp_en;
    logic [7:0]           dp_vec;
    logic [7:0]           blank_mask;
    logic [31:0]          digit_vec;
`ifdef FREQ_DISP_LZB_EN
    logic [2:0]           msd;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // FSM next-state logic; CONV runs exactly CNT_WIDTH cycles
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cnt_valid) state_d = StConv;
            StConv:  if (bit_cnt_q == 6'd1) state_d = StBlank;
            StBlank: state_d = StLoad;
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        cnt_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
    end

    // Capture saturation, double-dabble add-3 correction, dp and blanking vectors
    always_comb begin
        cnt_ext = 32'(cnt_data);
        sat     = (cnt_ext > SatMax);
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        dp_en  = 1'b0;
        dp_idx = 3'd0;
        case (range_q)
            2'd1:    begin dp_en = 1'b1; dp_idx = 3'd3; end
            2'd2:    begin dp_en = 1'b1; dp_idx = 3'd6; end
            default: begin dp_en = 1'b0; dp_idx = 3'd0; end
        endcase
        dp_vec = '0;
        if (dp_en) dp_vec[dp_idx] = 1'b1;
`ifdef FREQ_DISP_LZB_EN
        // With no dp, dp_idx is 0, so digit0 is still never blanked
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            blank_mask[i] = (3'(i) > msd) && (3'(i) > dp_idx);
        end
`else
        blank_mask = '0;
`endif
        digit_vec = '0;
        for (int i = 0; i < 8; i++) begin
            digit_vec[4*i +: 4] = blank_mask[i] ? BLANK_CODE : bcd_q[4*i +: 4];
        end
    end

    // Datapath: capture, shift steps, pending vectors, single-edge output load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            range_q      <= '0;
            ovf_pend_q   <= 1'b0;
            digit_pend_q <= '0;
            dp_pend_q    <= '0;
            disp_q       <= '0;
            dp_q         <= '0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cnt_valid) begin
                        // Saturated value fits whenever saturation can occur
                        bin_q      <= sat ? SatMax[CNT_WIDTH-1:0] : cnt_data;
                        range_q    <= range_sel;
                        ovf_pend_q <= sat;
                        bcd_q      <= '0;
                        bit_cnt_q  <= 6'(CNT_WIDTH);
                    end
                end
                StConv: begin
                    bcd_q     <= {bcd_adj[30:0], bin_q[CNT_WIDTH-1]};
                    bin_q     <= bin_q << 1;
                    bit_cnt_q <= bit_cnt_q - 6'd1;
                end
                StBlank: begin
                    digit_pend_q <= digit_vec;
                    dp_pend_q    <= dp_vec;
                end
                StLoad: begin
                    disp_q <= digit_pend_q;
                    dp_q   <= dp_pend_q;
                    ovf_q  <= ovf_pend_q;
                end
                default: ;
            endcase
        end
    end

    assign digit0 = disp_q[3:0];
    assign digit1 = disp_q[7:4];
    assign digit2 = disp_q[11:8];
    assign digit3 = disp_q[15:12];
    assign digit4 = disp_q[19:16];
    assign digit5 = disp_q[23:20];
    assign digit6 = disp_q[27:24];
    assign digit7 = disp_q[31:28];
    assign dp0    = dp_q[0];
    assign dp1    = dp_q[1];
    assign dp2    = dp_q[2];
    assign dp3    = dp_q[3];
    assign dp4    = dp_q[4];
    assign dp5    = dp_q[5];
    assign dp6    = dp_q[6];
    assign dp7    = dp_q[7];
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_freq_display_ctrl.sv
// Self-checking bench for freq_display_ctrl: directed cases plus randomized
// counts compared against a decimal-arithmetic reference model.
module tb_freq_display_ctrl;

    localparam int W = 27;
`ifdef FREQ_DISP_LZB_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cnt_valid = 1'b0;
    logic         cnt_ready;
    logic [W-1:0] cnt_data = '0;
    logic [1:0]   range_sel = '0;
    logic [3:0]   digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
    logic         dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7;
    logic         busy;
    logic         ovf;
    logic [31:0]  disp;
    logic [7:0]   dpv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign disp = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};
    assign dpv  = {dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0};

    freq_display_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_data  (cnt_data),
        .range_sel (range_sel),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .digit4    (digit4),
        .digit5    (digit5),
        .digit6    (digit6),
        .digit7    (digit7),
        .dp0       (dp0),
        .dp1       (dp1),
        .dp2       (dp2),
        .dp3       (dp3),
        .dp4       (dp4),
        .dp5       (dp5),
        .dp6       (dp6),
        .dp7       (dp7),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits of the saturated value, blanked above the
    // significant digits and the dp position when blanking is compiled in.
    function automatic logic [31:0] model_digits(input longint v, input int r);
        logic [31:0] res;
        longint      s;
        longint      t;
        longint      p;
        int          dpi;
        int          nd;
        s   = (v > 99_999_999) ? 99_999_999 : v;
        dpi = (r == 1) ? 3 : (r == 2) ? 6 : -1;
        nd  = 1;
        t   = s;
        while (t >= 10) begin
            t = t / 10;
            nd++;
        end
        res = '0;
        p   = 1;
        for (int i = 0; i < 8; i++) begin
            longint d;
            d = (s / p) % 10;
            res[4*i +: 4] = (Lzb && i >= nd && i > dpi) ? 4'hF : 4'(d);
            p = p * 10;
        end
        return res;
    endfunction

    function automatic logic [7:0] model_dp(input int r);
        return (r == 1) ? 8'h08 : (r == 2) ? 8'h40 : 8'h00;
    endfunction

    // One transaction; with hold set, cnt_valid stays high with junk data during CONV
    task automatic send_and_check(input logic [W-1:0] v, input logic [1:0] r,
                                  input bit hold, input string tag);
        logic [31:0] b_disp;
        logic [7:0]  b_dp;
        logic        b_ovf;
        int          n;
        bit          stable;
        n = 0;
        while (!cnt_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_pre"}, 32'(cnt_ready), 32'd1);
        b_disp    = disp;
        b_dp      = dpv;
        b_ovf     = ovf;
        cnt_data  = v;
        range_sel = r;
        cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = hold;
        cnt_data  = W'($urandom);
        range_sel = 2'($urandom);
        check({tag, "_busy"}, {30'd0, busy, cnt_ready}, 32'd2);
        n      = 0;
        stable = 1'b1;
        while (!cnt_ready && n < 100) begin
            if (disp !== b_disp || dpv !== b_dp || ovf !== b_ovf) stable = 1'b0;
            cnt_valid = hold && (n < 10);
            if (hold) cnt_data = W'($urandom);
            @(posedge clk); #1;
            n++;
        end
        cnt_valid = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(W + 2));
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_digits"}, disp, model_digits(longint'(v), int'(r)));
        check({tag, "_dp"}, 32'(dpv), 32'(model_dp(int'(r))));
        check({tag, "_ovf"}, 32'(ovf), (v > 99_999_999) ? 32'd1 : 32'd0);
        check({tag, "_idle"}, {30'd0, busy, cnt_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] v;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_hold_digits", disp, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_digits", disp, 32'd0);
        check("rst_dp", 32'(dpv), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ready_busy", {30'd0, busy, cnt_ready}, 32'd1);

        send_and_check(W'(12_345_678), 2'd0, 1'b0, "full");
        check("full_const", disp, 32'h1234_5678);
        send_and_check(W'(1234), 2'd0, 1'b0, "lz");
        check("lz_const", disp, Lzb ? 32'hFFFF_1234 : 32'h0000_1234);
        send_and_check(W'(5), 2'd2, 1'b0, "mhz");
        check("mhz_const", disp, Lzb ? 32'hF000_0005 : 32'h0000_0005);
        check("mhz_dp_const", 32'(dpv), 32'h40);
        send_and_check(W'(100_000_000), 2'd1, 1'b0, "ovf");
        check("ovf_const", disp, 32'h9999_9999);
        send_and_check(W'(0), 2'd0, 1'b0, "zero");
        send_and_check(W'(42), 2'd1, 1'b0, "khz");
        send_and_check(W'(7), 2'd3, 1'b0, "r3");
        send_and_check(W'(99_999_999), 2'd0, 1'b0, "max");
        send_and_check(W'(134_217_727), 2'd2, 1'b0, "allones");

        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 2))
                0:       v = W'($urandom_range(0, 9999));
                1:       v = W'($urandom % 100_000_000);
                default: v = W'($urandom);
            endcase
            send_and_check(v, 2'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", k));
        end

        send_and_check(W'(87_654_321), 2'd0, 1'b1, "hold");

        // Abort mid-conversion; display holds a nonzero value beforehand
        cnt_data  = W'(555);
        range_sel = 2'd1;
        cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_digits", disp, 32'd0);
        check("abort_dp", 32'(dpv), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_ready_busy", {30'd0, busy, cnt_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (W + 5) @(posedge clk);
        #1;
        check("abort_noload_digits", disp, 32'd0);
        check("abort_noload_dp", 32'(dpv), 32'd0);
        check("abort_noload_ready", 32'(cnt_ready), 32'd1);

        send_and_check(W'(31_415), 2'd1, 1'b0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_display_ctrl.md
# freq_display_ctrl

Sequencer between the frequency counter result and the `Seven_Segment_Display` driver. Accepts one binary count per valid/ready handshake, converts it to eight BCD digits with a serial double-dabble engine, applies range decimal point and leading-zero blanking, and updates all `digit0..7` / `dp0..7` registers in a single cycle so the scanning driver never shows a half-updated value. Sits directly upstream of `Seven_Segment_Display` and drives all of its digit and dp inputs.

## Interface

Parameters:
- `CNT_WIDTH`, 27, width of `cnt_data`; legal range 4..32.
- `BLANK_CODE`, 4'hF, nibble written to suppressed digits; the display decoder renders it dark.

Ports:
- `clk`  in  1  system clock, 50 MHz nominal.
- `rst`  in  1  asynchronous, active-low reset.
- `cnt_valid`  in  1  `cnt_data`/`range_sel` valid.
- `cnt_ready`  out  1  block idle, will accept on this edge.
- `cnt_data`  in  CNT_WIDTH  unsigned count to display.
- `range_sel`  in  2  0 = Hz, 1 = kHz, 2 = MHz, 3 = treated as 0.
- `digit0`..`digit7`  out  4 each  BCD digit; digit0 = least significant.
- `dp0`..`dp7`  out  1 each  decimal point enables.
- `busy`  out  1  conversion in progress, equal to ~`cnt_ready`.
- `ovf`  out  1  last displayed value was saturated.

## Operation

- FSM states: IDLE, CONV, BLANK, LOAD.
- IDLE: `cnt_ready`=1. When `cnt_valid`=1 at a rising edge, capture `cnt_data` and `range_sel`, clear the BCD accumulator, load a bit counter with CNT_WIDTH, and go to CONV.
- Saturation at capture: if `cnt_data` > 99_999_999, substitute 99_999_999 and set the internal ovf flag; otherwise clear the flag. With CNT_WIDTH ≤ 26 this path cannot trigger.
- CONV: one double-dabble step per cycle. Add 3 to each BCD nibble ≥ 5, then shift the MSB of the binary register into the 32-bit BCD accumulator. After CNT_WIDTH steps, go to BLANK.
- Range dp position: range 1 → dp index 3; range 2 → dp index 6; range 0/3 → none.
- BLANK: compute the pending digit and dp vectors.
  - The pending dp vector is all zero except the dp bit at the range dp position.
  - Blanking rule (when compiled in): each digit above the most significant nonzero digit and above the dp index is replaced with BLANK_CODE.
  - digit0 is never blanked, and neither is any digit at or below the dp index.
- LOAD: in one edge, write all `digit*`, `dp*` and `ovf`, then return to IDLE.
- `cnt_valid` is ignored outside IDLE. There is no queue, and data presented while busy is dropped.
- Reset values: `digit0..7`=0, `dp0..7`=0, `ovf`=0, `cnt_ready`=1, `busy`=0, FSM=IDLE.
- An asserted `rst` in any state aborts immediately (asynchronously) to the reset values. The in-flight value is discarded.

## Timing

- Handshake edge E0: capture occurs; `cnt_ready` goes 0 after E0.
- Edges E0+1 .. E0+CNT_WIDTH: shift steps.
- Edge E0+CNT_WIDTH+1: BLANK.
- Edge E0+CNT_WIDTH+2: outputs update and `cnt_ready` returns to 1.
- Latency is CNT_WIDTH+2 cycles (29 at the default). The earliest next capture is at E0+CNT_WIDTH+3.
- Outputs are registered and change only on the LOAD edge or on reset.

## Configuration

- `FREQ_DISP_LZB_EN` defined: leading-zero blanking with BLANK_CODE is applied as described.
- `FREQ_DISP_LZB_EN` undefined: BLANK is a pass-through, all eight digits are always shown as BCD (leading zeros shown as 0), and latency is unchanged.

## Test plan

- **Reset:** assert `rst`=0 for 5 cycles, then release. All digits = 0, all dp = 0, `ovf`=0, `cnt_ready`=1, `busy`=0.
- **Full-width value:** `cnt_data`=12_345_678, `range_sel`=0, valid for 1 cycle.
  - Nothing changes before E0+29.
  - At E0+29: digit7..digit0 = 1,2,3,4,5,6,7,8; dp = 0; `cnt_ready`=1.
- **Leading zeros:** `cnt_data`=1234, `range_sel`=0.
  - With LZB_EN: digit7..4 = F and digit3..0 = 1,2,3,4.
  - Without LZB_EN: digit7..4 = 0.
- **MHz range:** `cnt_data`=5, `range_sel`=2.
  - dp6=1 and all other dp = 0.
  - digit6..1 = 0 and digit0 = 5.
  - With LZB_EN: digit7 = F.
- **Overflow:** `cnt_data`=100_000_000 gives all digits = 9 and `ovf`=1. A following `cnt_data`=0 gives digit0 = 0 (others F under LZB_EN) and `ovf`=0.
- **Busy and abort:**
  - Hold `cnt_valid`=1 with new data during CONV. That data is ignored and the first value is displayed.
  - Assert `rst` at E0+10 of a new conversion. Outputs go to reset values immediately, with no LOAD afterwards.
